// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package fetch_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    localparam int unsigned FQ_DEPTH = 2;
    localparam logic [31:0] PC_STEP  = 32'd4;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO holding fetched instructions together with their PC.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [31:0]      push_pc,
    input  logic [WIDTH-1:0] push_instr,
    input  logic             pop,
    output logic [1:0]       count,
    output logic [31:0]      head_pc,
    output logic [WIDTH-1:0] head_instr
);

    logic [31:0]      pc_mem    [FQ_DEPTH];
    logic [WIDTH-1:0] instr_mem [FQ_DEPTH];
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       count_q;

    assign count      = count_q;
    assign head_pc    = pc_mem[rd_ptr];
    assign head_instr = instr_mem[rd_ptr];

    // Storage and pointers; flush wins over a same-cycle push, a pop is already consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FQ_DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count_q <= 2'd0;
        end else if (flush) begin
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (push) begin
                pc_mem[wr_ptr]    <= push_pc;
                instr_mem[wr_ptr] <= push_instr;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, issues imem reads, buffers
// responses for decode and handles redirects (including misaligned targets).
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_en,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic             imem_rd_en,
    output logic [31:0]      imem_pc,
    input  logic [WIDTH-1:0] imem_instr,
    output logic             if_valid,
    input  logic             if_ready,
    output logic [WIDTH-1:0] if_instr,
    output logic [31:0]      if_pc,
    output logic             fetch_fault
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  tag;
    logic         inflight;
    logic [1:0]   count;
    logic         pop;
    logic         push;
    logic         issue;
    logic [2:0]   outstanding;

    assign pop         = if_valid && if_ready;
    assign outstanding = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
    // Gated by rst so no read escapes while reset is held.
    assign issue       = !rst && (state == RUN) && fetch_en && !redirect_valid &&
                         (outstanding < 3'(FQ_DEPTH));
    // A response landing in a redirect cycle belongs to the old path and is dropped.
    assign push        = inflight && !redirect_valid;

    assign imem_rd_en  = issue;
    assign imem_pc     = pc;
    assign if_valid    = (count != 2'd0);
    assign fetch_fault = (state == FAULT);

    // PC, in-flight tracking and RUN/FAULT state; redirect overrides issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            pc       <= RESET_PC;
            tag      <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                tag <= pc;
                pc  <= pc + PC_STEP;
            end
            if (redirect_valid) begin
                pc    <= redirect_pc;
                state <= (redirect_pc[1:0] != 2'b00) ? FAULT : RUN;
            end
        end
    end

    fetch_queue #(
        .WIDTH (WIDTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .push       (push),
        .push_pc    (tag),
        .push_instr (imem_instr),
        .pop        (pop),
        .count      (count),
        .head_pc    (if_pc),
        .head_instr (if_instr)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus random traffic,
// checked by a scoreboard fed from a program-order reference model.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_rd_en;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        fetch_fault;

    int total = 0;
    int bad   = 0;
    int n_pop = 0;

    logic [31:0] rom [64];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] next_pc = 32'h0;
    bit          mfault  = 1'b0;

    always #5 clk = ~clk;

    fetch_ctrl #(
        .WIDTH    (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_rd_en     (imem_rd_en),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .fetch_fault    (fetch_fault)
    );

    // Synchronous instruction memory: data is valid the cycle after a read.
    always @(posedge clk) begin
        if (imem_rd_en) imem_instr <= rom[imem_pc[7:2]];
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Program-order model: delivered PCs run sequentially from the last redirect target.
    task automatic topup();
        while (!mfault && exp_q.size() < 4) begin
            exp_t e;
            e.pc    = next_pc;
            e.instr = rom[next_pc[7:2]];
            exp_q.push_back(e);
            next_pc = next_pc + 32'd4;
        end
    endtask

    // Monitor: compare every handshake against the model, then apply redirects.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            next_pc = 32'h0;
            mfault  = 1'b0;
        end else begin
            check("fetch_fault", {31'b0, fetch_fault}, {31'b0, mfault});
            if (mfault) begin
                check("fault_rd_en", {31'b0, imem_rd_en}, 32'd0);
                check("fault_if_valid", {31'b0, if_valid}, 32'd0);
            end
            if (if_valid && if_ready) begin
                topup();
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got pc %h expected none", if_pc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("if_pc", if_pc, e.pc);
                    check("if_instr", if_instr, e.instr);
                    n_pop++;
                end
            end
            if (redirect_valid) begin
                exp_q.delete();
                next_pc = redirect_pc;
                mfault  = (redirect_pc[1:0] != 2'b00);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_en"},    {31'b0, imem_rd_en},  32'd0);
        check({tag, "_imem_pc"},  imem_pc,              32'h0);
        check({tag, "_if_valid"}, {31'b0, if_valid},    32'd0);
        check({tag, "_if_instr"}, if_instr,             32'h0);
        check({tag, "_if_pc"},    if_pc,                32'h0);
        check({tag, "_fault"},    {31'b0, fetch_fault}, 32'd0);
    endtask

    task automatic pulse_redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        step();
        redirect_valid = 1'b0;
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int pulses;
        int valids;
        int start_pop;
        bit found;

        for (int i = 0; i < 64; i++) rom[i] = $urandom;
        rst            = 1'b1;
        fetch_en       = 1'b1;
        if_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        // Reset values while held in reset.
        step();
        step();
        check_reset_outputs("reset");

        // First issue in the first cycle out of reset, data visible two cycles later.
        rst = 1'b0;
        #1;
        check("first_rd_en", {31'b0, imem_rd_en}, 32'd1);
        check("first_imem_pc", imem_pc, 32'h0);
        step();
        check("first_n1_valid", {31'b0, if_valid}, 32'd0);
        step();
        check("first_n2_valid", {31'b0, if_valid}, 32'd1);
        check("first_n2_pc", if_pc, 32'h0);

        // Streaming: one instruction per cycle for 22 words.
        valids = 0;
        for (int i = 0; i < 22; i++) begin
            if (if_valid) valids++;
            step();
        end
        check("stream_no_bubbles", valids, 22);

        // Backpressure: two words outstanding, no further issue.
        if_ready = 1'b0;
        #1;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            if (imem_rd_en) pulses++;
            step();
        end
        check("stall_rd_pulses", pulses, 0);
        check("stall_valid", {31'b0, if_valid}, 32'd1);
        if_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();

        // Redirect to 0x40 while the read of 0x10 is in flight.
        rst = 1'b1;
        step();
        rst = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            #1;
            if (imem_rd_en && imem_pc == 32'h10) found = 1'b1;
            else step();
        end
        check("find_issue_0x10", {31'b0, found}, 32'd1);
        step();
        pulse_redirect(32'h40);
        check("redir_n1_valid", {31'b0, if_valid}, 32'd0);
        check("redir_n1_rd_en", {31'b0, imem_rd_en}, 32'd1);
        check("redir_n1_imem_pc", imem_pc, 32'h40);
        step();
        check("redir_n2_valid", {31'b0, if_valid}, 32'd0);
        step();
        check("redir_n3_valid", {31'b0, if_valid}, 32'd1);
        check("redir_n3_pc", if_pc, 32'h40);
        for (int i = 0; i < 4; i++) step();

        // Misaligned redirect enters FAULT; an aligned one leaves it.
        pulse_redirect(32'h43);
        for (int i = 0; i < 3; i++) begin
            check("mis_fault", {31'b0, fetch_fault}, 32'd1);
            check("mis_rd_en", {31'b0, imem_rd_en}, 32'd0);
            check("mis_valid", {31'b0, if_valid}, 32'd0);
            step();
        end
        pulse_redirect(32'h47);
        check("mis_again_fault", {31'b0, fetch_fault}, 32'd1);
        pulse_redirect(32'h20);
        check("unfault", {31'b0, fetch_fault}, 32'd0);
        step();
        step();
        check("unfault_n3_valid", {31'b0, if_valid}, 32'd1);
        check("unfault_n3_pc", if_pc, 32'h20);
        for (int i = 0; i < 3; i++) step();

        // Redirect in the same cycle as a pop from a full queue.
        if_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        if_ready = 1'b1;
        pulse_redirect(32'h80);
        step();
        step();
        check("pop_redir_pc", if_pc, 32'h80);
        for (int i = 0; i < 3; i++) step();

        // Reset mid-stream with the queue full.
        if_ready = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("full_before_rst", {31'b0, if_valid}, 32'd1);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        rst      = 1'b0;
        if_ready = 1'b1;
        #1;
        check("restart_imem_pc", imem_pc, 32'h0);
        step();
        step();
        check("restart_pc", if_pc, 32'h0);
        check("restart_valid", {31'b0, if_valid}, 32'd1);

        // Random traffic against the reference model.
        start_pop = n_pop;
        for (int i = 0; i < 3000; i++) begin
            step();
            fetch_en = ($urandom_range(0, 9) < 8);
            if_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 19) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
                if ($urandom_range(0, 4) == 0) redirect_pc[1:0] = 2'($urandom_range(1, 3));
            end else begin
                redirect_valid = 1'b0;
            end
        end
        redirect_valid = 1'b0;
        step();
        check("random_progress", {31'b0, (n_pop - start_pop) > 200}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch controller that sequences the synchronous instruction memory (`imem`). It owns the program counter and issues one word-aligned read per cycle while the downstream decode stage can absorb it. It buffers returned instructions with their PC in a 2-entry queue and handles branch/jump redirects, squashing any read already in flight. It sits between `imem` and the decode stage of the RISC-V core.

## Interface
- `WIDTH`, 32, instruction width; must match `imem` WIDTH.
- `RESET_PC`, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `fetch_en`  in  1  permits new imem reads; low holds the PC and issues nothing.
- `redirect_valid`  in  1  one-cycle pulse requesting a PC change.
- `redirect_pc`  in  32  redirect target.
- `imem_rd_en`  out  1  to `imem` rd_en.
- `imem_pc`  out  32  to `imem` pc.
- `imem_instr`  in  WIDTH  from `imem` instr; valid the cycle after a read is issued.
- `if_valid`  out  1  instruction available to decode.
- `if_ready`  in  1  decode accepts; transfer when `if_valid && if_ready`.
- `if_instr`  out  WIDTH  instruction at queue head.
- `if_pc`  out  32  PC of `if_instr`.
- `fetch_fault`  out  1  high while halted on a misaligned redirect.

## Operation
- States: RUN, FAULT. Reset enters RUN with pc = RESET_PC, queue empty, in-flight flag clear.
- Issue condition: state RUN, `fetch_en`, no `redirect_valid`, and (count + inflight − pop) < 2, where pop = `if_valid && if_ready`. `imem_rd_en` is asserted only when the issue condition holds; `imem_pc` = pc always. On issue: inflight <= 1, tag <= pc, pc <= pc + 4 (mod 2^32).
- Response: in the cycle after an issue, `imem_instr` and the tag are written to the queue unless squashed. `imem_instr` is ignored in every other cycle.
- Queue: 2 entries, FIFO order; push and pop in the same cycle are both allowed. `if_valid` = (count != 0); `if_instr`/`if_pc` come from the head entry.
- Redirect (priority over issue): a pop in the same cycle completes normally. The queue is then flushed, any in-flight response is squashed (not pushed next cycle), and pc <= `redirect_pc`.
- If `redirect_pc[1:0]` != 0, the redirect additionally moves the state to FAULT: no issues, `fetch_fault` = 1. Only an aligned redirect returns the state to RUN, with pc = target. A misaligned redirect while in FAULT keeps the state in FAULT.
- `fetch_en` low with a read in flight: the response is still captured.
- Reset mid-operation clears all state immediately. Any imem response arriving after reset is discarded.

## Timing
- Reset values: `imem_rd_en` 0, `imem_pc` RESET_PC, `if_valid` 0, `if_instr` 0, `if_pc` 0, `fetch_fault` 0.
- First issue is in the first cycle with rst low and `fetch_en` high. `if_valid` rises 2 cycles after the issue cycle (issue at N, imem data in N+1, queued and visible in N+2).
- Redirect in cycle N: the first read of the target is issued in N+1, and the target instruction is at the head in N+3. The queue is empty in N+1 and N+2.
- Steady state with `if_ready` held high: one instruction per cycle, no bubbles.
- `if_ready` low: at most 2 outstanding words (queued + in flight). Issue stops, and there is no overflow and no loss.
- `fetch_fault` asserts the cycle after a misaligned redirect and deasserts the cycle after the next aligned redirect.

## Structure
- `fetch_pkg`: `fetch_state_t` enum {RUN, FAULT}, `FQ_DEPTH = 2`, `PC_STEP = 4`.
- Sub-module `fetch_queue`: 2-entry synchronous FIFO storing {pc, instr}, with push/pop/count/flush ports. `fetch_ctrl` holds the PC, in-flight/squash logic and FSM.

## Test plan
- Reset then `fetch_en` = 1 with `if_ready` = 1: `if_pc` sequence 0, 4, 8, … one per cycle, with `if_instr` matching the imem hex model at pc/4 for 22 words.
- Hold `if_ready` = 0 for 5 cycles mid-stream: `imem_rd_en` stays low after 2 outstanding words. On release, PCs continue with no gap and no duplicate.
- Redirect to 0x40 while a read of 0x10 is in flight: 0x10 is never presented, and the next `if_pc` is 0x40 exactly 3 cycles after the pulse.
- Redirect to 0x43: `fetch_fault` = 1, `imem_rd_en` = 0, `if_valid` = 0. A later redirect to 0x20 clears the fault, and `if_pc` = 0x20 follows.
- Assert rst for one cycle mid-stream with the queue full: outputs take reset values immediately, and fetch restarts at RESET_PC.
- Redirect in the same cycle as a pop: the popped entry is delivered once, and the remaining queue entry is dropped.
